// File: rtl/onchip_copy_pkg.sv
// Shared types and default sizing for the on-chip memory copy master.
package onchip_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned DEF_ADDR_W       = 11;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_READ_LATENCY = 1;
    localparam int unsigned DEF_LEN_W        = DEF_ADDR_W + 1;

endpackage

// File: rtl/onchip_copy_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head; holds one burst.
module onchip_copy_fifo
    import onchip_copy_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM initiator copying a block of words inside a single-port on-chip memory,
// in bursts of reads into a local FIFO followed by writes back out.
module onchip_memory_copy_master
    import onchip_copy_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned LEN_W        = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len_words,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        burst_q, burst_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic [LEN_W-1:0]        rem_after;
    logic [ADDR_W-1:0]       src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]       dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cs_q, cs_d;
    logic                    wr_q, wr_d;
    logic                    clken_q, clken_d;
    logic [READ_LATENCY-1:0] rv_q, rv_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]       fifo_head;

    function automatic logic [LEN_W-1:0] next_burst(input logic [LEN_W-1:0] rem);
        return (rem > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH) : rem;
    endfunction

    // Outputs are registered: each branch sets up the access for the following cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        remaining_d = remaining_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        clken_d     = 1'b1;
        rem_after   = remaining_q - burst_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d      = 1'b1;
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = len_words;
                    if (len_words == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        burst_d   = next_burst(len_words);
                        cs_d      = 1'b1;
                        addr_d    = src_addr;
                        src_ptr_d = src_addr + ADDR_W'(1);
                        cnt_d     = LEN_W'(1);
                    end
                end
            end
            READ: begin
                if (cnt_q == burst_q) begin
                    state_d = DRAIN;
                    cnt_d   = LEN_W'(1);
                end else begin
                    cs_d      = 1'b1;
                    addr_d    = src_ptr_q;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == LEN_W'(READ_LATENCY)) begin
                    state_d   = WRITE;
                    cs_d      = 1'b1;
                    wr_d      = 1'b1;
                    addr_d    = dst_ptr_q;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    cnt_d     = LEN_W'(1);
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            WRITE: begin
                if (cnt_q == burst_q) begin
                    remaining_d = rem_after;
                    if (rem_after == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        burst_d   = next_burst(rem_after);
                        cs_d      = 1'b1;
                        addr_d    = src_ptr_q;
                        src_ptr_d = src_ptr_q + ADDR_W'(1);
                        cnt_d     = LEN_W'(1);
                    end
                end else begin
                    cs_d      = 1'b1;
                    wr_d      = 1'b1;
                    addr_d    = dst_ptr_q;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read-valid pipeline runs regardless of state so capture timing is fixed.
    always_comb begin
        rv_d    = '0;
        rv_d[0] = cs_q & ~wr_q;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rv_d[i] = rv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            burst_q     <= '0;
            remaining_q <= '0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            clken_q     <= 1'b1;
            rv_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            remaining_q <= remaining_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            clken_q     <= clken_d;
            rv_q        <= rv_d;
        end
    end

    assign fifo_push = rv_q[READ_LATENCY-1];
    assign fifo_pop  = cs_q & wr_q;

    onchip_copy_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (readdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full))
        else $error("copy fifo push while full");
    assert property (@(posedge clk) disable iff (reset) !(fifo_pop && fifo_empty))
        else $error("copy fifo pop while empty");

    assign busy       = busy_q;
    assign done       = done_q;
    assign address    = addr_q;
    assign byteenable = '1;
    assign chipselect = cs_q;
    assign write      = wr_q;
    assign writedata  = (cs_q && wr_q) ? fifo_head : '0;
    assign clken      = clken_q;

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Scoreboard bench for onchip_memory_copy_master against a 2048x32 memory with 1-cycle read latency.
module tb_onchip_memory_copy_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] src_addr = '0;
    logic [10:0] dst_addr = '0;
    logic [11:0] len_words = '0;
    logic        busy, done, chipselect, write, clken;
    logic [10:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    onchip_memory_copy_master #(
        .ADDR_W       (11),
        .DATA_W       (32),
        .FIFO_DEPTH   (4),
        .READ_LATENCY (1),
        .LEN_W        (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } acc_t;

    acc_t        exp_q[$];
    logic [31:0] snap[$];
    logic [31:0] mem [2048];
    bit          mem_ready = 1'b0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    int unsigned t_done = 0;
    bit          win_en = 1'b0;
    bit          mon_en = 1'b0;
    int unsigned done_cnt = 0;
    int unsigned done_base = 0;
    int unsigned acc_cnt = 0;
    logic [10:0] snap_dst;
    int unsigned snap_len;
    int unsigned n_tests = 0;
    int unsigned n_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; contents seeded on the first edge, mem[0..3] hold known words.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) begin
                mem[i] <= (i < 4) ? (32'hA0A0_0000 + 32'(i)) : $urandom;
            end
            mem_ready <= 1'b1;
        end else if (chipselect && clken) begin
            if (write) mem[address] <= writedata;
            else       readdata <= mem[address];
        end
    end

    always @(negedge clk) begin
        acc_t e;
        if (mon_en && !reset) begin
            check_eq("busy", 64'(busy), 64'(win_en && cyc > t0 && cyc <= t_done));
            if (chipselect) begin
                acc_cnt++;
                check_eq("access_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("access_cycle", 64'(cyc), 64'(e.cyc));
                    check_eq("access_write", 64'(write), 64'(e.wr));
                    check_eq("access_addr", 64'(address), 64'(e.addr));
                    if (e.wr) check_eq("access_wdata", 64'(writedata), 64'(e.data));
                end
            end
            if (done) begin
                done_cnt++;
                check_eq("done_expected", 64'(win_en), 64'd1);
                check_eq("done_cycle", 64'(cyc), 64'(t_done));
            end
        end
    end

    task automatic launch(input logic [10:0] s, input logic [10:0] d, input logic [11:0] n);
        int unsigned t, rem, b, idx;
        logic [10:0] a;
        @(posedge clk); #1;
        t0 = cyc; t = cyc; rem = n; idx = 0;
        snap.delete(); snap_dst = d; snap_len = n;
        for (int i = 0; i < int'(n); i++) begin
            a = s + 11'(i);
            snap.push_back(mem[a]);
        end
        while (rem > 0) begin
            b = (rem > 4) ? 4 : rem;
            for (int i = 0; i < int'(b); i++)
                exp_q.push_back('{1'b0, s + 11'(idx + i), 32'h0, t + 1 + i});
            for (int i = 0; i < int'(b); i++)
                exp_q.push_back('{1'b1, d + 11'(idx + i), snap[idx + i], t + b + 2 + i});
            t += 2 * b + 1; idx += b; rem -= b;
        end
        t_done = t + 1; win_en = 1'b1; done_base = done_cnt;
        start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned lim;
        lim = t_done + 20;
        while (done_cnt == done_base && cyc < lim) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        check_eq("done_count", 64'(done_cnt - done_base), 64'd1);
        check_eq("leftover_accesses", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_mem();
        logic [10:0] a;
        for (int i = 0; i < int'(snap_len); i++) begin
            a = snap_dst + 11'(i);
            check_eq("dst_data", 64'(mem[a]), 64'(snap[i]));
        end
    endtask

    initial begin
        logic [31:0] keep400;
        int unsigned base;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_cs", 64'(chipselect), 64'd0);
        check_eq("rst_write", 64'(write), 64'd0);
        check_eq("rst_addr", 64'(address), 64'd0);
        check_eq("rst_wdata", 64'(writedata), 64'd0);
        check_eq("rst_be", 64'(byteenable), 64'hF);
        check_eq("rst_clken", 64'(clken), 64'd1);
        reset = 1'b0; mon_en = 1'b1;
        repeat (2) @(posedge clk);

        launch(11'd0, 11'd100, 12'd4);           // basic copy
        wait_done(); check_mem();

        launch(11'd500, 11'd600, 12'd0);         // zero length
        wait_done();

        launch(11'd2045, 11'd10, 12'd6);         // two bursts, source wraps
        wait_done(); check_mem();

        keep400 = mem[400];                      // start while busy is ignored
        launch(11'd200, 11'd300, 12'd8);
        repeat (2) @(posedge clk); #1;
        start = 1'b1; src_addr = 11'd50; dst_addr = 11'd400; len_words = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(); check_mem();
        check_eq("ignored_dst", 64'(mem[400]), 64'(keep400));

        launch(11'd300, 11'd700, 12'd8);         // reset in first write cycle
        repeat (5) @(posedge clk); #1;
        reset = 1'b1; win_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        check_eq("midrst_cs", 64'(chipselect), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        repeat (15) @(posedge clk); #1;
        check_eq("midrst_no_done", 64'(done_cnt), 64'(done_base));
        launch(11'd20, 11'd800, 12'd5);
        wait_done(); check_mem();

        base = acc_cnt;                          // whole memory in place
        launch(11'd0, 11'd0, 12'd2048);
        check_eq("full_done_cycle", 64'(t_done - t0), 64'(1 + 512 * 9));
        wait_done(); check_mem();
        check_eq("full_accesses", 64'(acc_cnt - base), 64'd4096);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
